// File: rtl/seq_detect_pkg.sv
// ============================================================================
// Module   : seq_detect_pkg
// Brief    : State encodings and pattern constant shared by the 0101 detectors
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detect_pkg;

    localparam logic [3:0] c_pattern = 4'b0101;

    typedef enum logic [1:0] {
        M0 = 2'd0,
        M1 = 2'd1,
        M2 = 2'd2,
        M3 = 2'd3
    } mealy_state_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } moore_state_t;

endpackage

`default_nettype wire

// File: rtl/mealy_fsm.sv
// ============================================================================
// Module   : mealy_fsm
// Brief    : Mealy detector for 0101, flag is combinational from state and din
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mealy_fsm
    import seq_detect_pkg::*;
(
    output logic flag,
    input  logic din,
    input  logic clk,
    input  logic rst
);

    mealy_state_t r_state;
    mealy_state_t w_next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= M0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = M0;
        flag         = 1'b0;
        case (r_state)
            M0: w_next_state = din ? M0 : M1;
            M1: w_next_state = din ? M2 : M1;
            M2: w_next_state = din ? M0 : M3;
            M3: begin
                // In M3 the last bit of the pattern completes the match; overlap keeps "01".
                w_next_state = din ? M2 : M1;
                flag         = (din == c_pattern[0]);
            end
            default: w_next_state = M0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/moore_fsm.sv
// ============================================================================
// Module   : moore_fsm
// Brief    : Moore detector for 0101, flag decoded from state alone
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module moore_fsm
    import seq_detect_pkg::*;
(
    output logic flag,
    input  logic din,
    input  logic clk,
    input  logic rst
);

    moore_state_t r_state;
    moore_state_t w_next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S0;
        case (r_state)
            S0: w_next_state = din ? S0 : S1;
            S1: w_next_state = din ? S2 : S1;
            S2: w_next_state = din ? S0 : S3;
            S3: w_next_state = din ? S4 : S1;
            S4: w_next_state = din ? S0 : S3;
            // Encodings 5..7 recover to idle.
            default: w_next_state = S0;
        endcase
    end

    assign flag = (r_state == S4);

endmodule

`default_nettype wire

// File: rtl/seq_detect_fsm.sv
// ============================================================================
// Module   : seq_detect_fsm
// Brief    : Side-by-side Mealy and Moore 0101 detectors on one serial input
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_fsm (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic flag_mealy,
    output logic flag_moore
);

    mealy_fsm u_mealy (
        .flag (flag_mealy),
        .din  (din),
        .clk  (clk),
        .rst  (rst)
    );

    moore_fsm u_moore (
        .flag (flag_moore),
        .din  (din),
        .clk  (clk),
        .rst  (rst)
    );

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_fsm.sv
// ============================================================================
// Module   : tb_seq_detect_fsm
// Brief    : Vector table, corner sequences and random stream vs history model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_fsm;

    logic clk;
    logic rst;
    logic din;
    logic flag_mealy;
    logic flag_moore;

    int n_vec;
    int n_err;

    // Bits sampled since the last reset, newest at the back, at most four kept.
    bit hist[$];

    typedef struct {
        logic d;
        logic exp_mealy;
        logic exp_moore;
    } vec_t;

    vec_t tbl[12];

    seq_detect_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .flag_mealy (flag_mealy),
        .flag_moore (flag_moore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // The four most recent bits (with d as the newest) spell 0101.
    function automatic logic model_mealy(input logic d);
        logic [3:0] w;
        if (hist.size() < 3) return 1'b0;
        w = {logic'(hist[hist.size()-3]), logic'(hist[hist.size()-2]),
             logic'(hist[hist.size()-1]), d};
        return (w == 4'b0101);
    endfunction

    function automatic logic model_moore();
        logic [3:0] w;
        if (hist.size() < 4) return 1'b0;
        w = {logic'(hist[0]), logic'(hist[1]), logic'(hist[2]), logic'(hist[3])};
        return (w == 4'b0101);
    endfunction

    // Entered and left just after a rising edge.
    task automatic step(input logic d, input string name);
        din = d;
        @(negedge clk);
        chk({name, "_mealy"}, flag_mealy, model_mealy(d));
        chk({name, "_moore"}, flag_moore, model_moore());
        @(posedge clk);
        #1;
        hist.push_back(d);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic rst_pulse(input string name);
        #1;
        rst = 1'b1;
        #1;
        chk({name, "_rst_mealy"}, flag_mealy, 1'b0);
        chk({name, "_rst_moore"}, flag_moore, 1'b0);
        rst = 1'b0;
        hist.delete();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        din   = 1'b0;

        // Expected values worked out by hand from idle: 0101 01 1 0101 1.
        tbl[0]  = '{1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_mealy", flag_mealy, 1'b0);
        chk("reset_moore", flag_moore, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            din = tbl[i].d;
            @(negedge clk);
            chk($sformatf("tbl%0d_mealy", i), flag_mealy, tbl[i].exp_mealy);
            chk($sformatf("tbl%0d_moore", i), flag_moore, tbl[i].exp_moore);
            @(posedge clk);
            #1;
            hist.push_back(tbl[i].d);
            if (hist.size() > 4) void'(hist.pop_front());
        end

        // Never matches.
        rst_pulse("nomatch");
        begin
            logic [9:0] nm;
            nm = 10'b1110110011;
            for (int i = 9; i >= 0; i--) step(nm[i], "nomatch");
        end

        // Reset after 010 loses progress; next 1 must not flag.
        rst_pulse("mid");
        step(1'b0, "mid");
        step(1'b1, "mid");
        step(1'b0, "mid");
        rst_pulse("mid");
        step(1'b1, "mid_after");
        step(1'b0, "mid_re");
        step(1'b1, "mid_re");
        step(1'b0, "mid_re");
        step(1'b1, "mid_re");
        // Moore flag is high here; reset must drop it without a clock edge.
        chk("moore_high_before_rst", flag_moore, 1'b1);
        rst_pulse("moore_drop");

        // Mealy flag follows din mid-cycle while in the "010" state.
        step(1'b0, "glitch");
        step(1'b1, "glitch");
        step(1'b0, "glitch");
        din = 1'b0;
        #1;
        chk("glitch_low", flag_mealy, 1'b0);
        din = 1'b1;
        #1;
        chk("glitch_high", flag_mealy, 1'b1);
        din = 1'b0;
        #1;
        chk("glitch_fall", flag_mealy, 1'b0);
        step(1'b1, "glitch_end");

        // Random stream with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) rst_pulse("rnd");
            step(logic'($urandom_range(0, 1)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
